action_irq_arbiter: RTL and testbench
=====================================

# action_irq_arbiter

Multi-kernel interrupt arbiter and ready sequencer sitting between the KERNEL_NUM compute kernels of an action framework and the SNAP core's single interrupt port (o_interrupt / o_interrupt_src / i_interrupt_ack). It replaces the fixed one-cycle app_ready flop with a parametrised power-up delay. It serialises per-kernel interrupt requests with round-robin fairness and tags each forwarded source word with the kernel index. An optional ack timeout keeps a lost acknowledge from deadlocking the kernels.

## Interface
Parameters:
- KERNEL_NUM, 8, number of requesting kernels (1..256)
- INT_BITS, 64, width of o_interrupt_src
- KSRC_BITS, 32, per-kernel source word width; KSRC_BITS+8 <= INT_BITS
- READY_DELAY, 1, rising edges after reset release before o_app_ready asserts (>=1)
- ACK_TIMEOUT, 0, cycles to wait for i_interrupt_ack; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_kernel_irq  in  KERNEL_NUM  level request per kernel; held until its ack pulse
- i_kernel_src  in  KERNEL_NUM*KSRC_BITS  source word; kernel k at [k*KSRC_BITS +: KSRC_BITS]
- o_kernel_irq_ack  out  KERNEL_NUM  one-cycle one-hot completion pulse
- o_interrupt  out  1  interrupt to SNAP core
- o_interrupt_src  out  INT_BITS  {zero pad, kernel index[7:0], captured source[KSRC_BITS-1:0]}
- i_interrupt_ack  in  1  acknowledge from SNAP core
- o_app_ready  out  1  ready indication to the framework
- o_timeout_err  out  1  sticky flag: a timeout has occurred
- i_err_clear  in  1  clears o_timeout_err
- o_busy  out  1  high whenever state != IDLE

## Operation
- Reset (async assert, any state): all outputs 0, state IDLE, round-robin pointer 0, ready and timeout counters 0.
- Ready counter: counts from the first rising edge after rst_n deasserts. o_app_ready becomes 1 on edge READY_DELAY and stays 1. READY_DELAY=1 gives legacy one-cycle behaviour.
- FSM states:
  - IDLE: if o_app_ready and any i_kernel_irq bit is set, grant the first set bit at or after the pointer, wrapping modulo KERNEL_NUM. On grant: capture its source word and index into o_interrupt_src, set o_interrupt, clear the timeout counter, go to REQ. Pointer becomes grant+1 mod KERNEL_NUM.
  - REQ: o_interrupt held 1 and o_interrupt_src stable.
    - i_interrupt_ack=1: o_interrupt is cleared and o_kernel_irq_ack[grant] pulses; go to RELEASE.
    - Otherwise, if ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT-1: same exit, and o_timeout_err is also set.
    - Otherwise the counter increments.
  - RELEASE: one cycle. The ack pulse ends; go to IDLE. o_interrupt_src retains its last value.
- Ack and timeout in the same cycle: ack wins; o_timeout_err is not set.
- i_interrupt_ack outside REQ is ignored.
- Requests arriving while REQ/RELEASE wait in IDLE arbitration; none are lost while held.
- i_err_clear and a new timeout in the same cycle: set wins.
- Index field is $clog2-sized, zero-extended into 8 bits; pad bits above KSRC_BITS+8 are 0.

## Timing
- Request seen high at edge t (IDLE, ready): o_interrupt=1 and src valid after edge t.
- Ack sampled at edge t: o_interrupt=0 and kernel ack=1 after t; ack=0 after t+1; next grant possible at edge t+2.
- Kernel must drop i_kernel_irq by edge t+2 (registered deassert suffices), otherwise it is re-granted.
- Minimum interrupt spacing: 3 cycles per request.
- Timeout: o_interrupt is high for exactly ACK_TIMEOUT cycles when no ack arrives.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Power-up with READY_DELAY=4 and all requests high: o_app_ready rises on the 4th edge after reset release; no o_interrupt before that; first grant is kernel 0.
- Kernels 2 and 5 request simultaneously with sources 0xAAAA0002 / 0xBBBB0005; ack each after 3 cycles: o_interrupt_src = 0x..02_AAAA0002 then 0x..05_BBBB0005; exactly one ack pulse to each kernel, in that order.
- All 8 kernels request permanently: grants follow 0,1,...,7,0 with one interrupt every 3 cycles when acked immediately.
- ACK_TIMEOUT=10, never ack: o_interrupt high exactly 10 cycles, o_timeout_err=1, kernel ack pulses. Then i_err_clear clears the flag. A variant with ack on cycle 10: flag stays 0.
- Assert rst_n low mid-REQ: all outputs 0 immediately (async); after release, pointer restarts at 0 and o_app_ready repeats its delay.

Source files
------------

// File: rtl/action_irq_arbiter.sv
// Round-robin interrupt arbiter between KERNEL_NUM kernels and the single SNAP interrupt port,
// with a parametrised power-up ready delay and an optional acknowledge timeout.
module action_irq_arbiter #(
   parameter int KERNEL_NUM  = 8,
   parameter int INT_BITS    = 64,
   parameter int KSRC_BITS   = 32,
   parameter int READY_DELAY = 1,
   parameter int ACK_TIMEOUT = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [KERNEL_NUM-1:0]           i_kernel_irq,
   input  logic [KERNEL_NUM*KSRC_BITS-1:0] i_kernel_src,
   output logic [KERNEL_NUM-1:0]           o_kernel_irq_ack,
   output logic                            o_interrupt,
   output logic [INT_BITS-1:0]             o_interrupt_src,
   input  logic                            i_interrupt_ack,
   output logic                            o_app_ready,
   output logic                            o_timeout_err,
   input  logic                            i_err_clear,
   output logic                            o_busy
);

   localparam int IDX_W = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
   localparam int RD_W  = (READY_DELAY > 1) ? $clog2(READY_DELAY) : 1;
   localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(READY_DELAY - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = (ACK_TIMEOUT > 0) ? TO_W'(ACK_TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KERNEL_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_REL
   } state_t;

   state_t state, state_d;

   logic [RD_W-1:0]     rdy_cnt;
   logic [TO_W-1:0]     to_cnt, to_cnt_d;
   logic [IDX_W-1:0]    ptr, ptr_d;
   logic [IDX_W-1:0]    gsel, gsel_d;
   logic [IDX_W-1:0]    grant_idx;
   logic [IDX_W-1:0]    cand;
   logic                grant_valid;
   logic                grant_take;
   logic                ack_hit;
   logic                to_hit;
   logic [INT_BITS-1:0] grant_word;
   logic [KSRC_BITS-1:0] ksrc [KERNEL_NUM];

   logic                  int_d;
   logic [INT_BITS-1:0]   src_d;
   logic [KERNEL_NUM-1:0] kack_d;
   logic                  err_d;
   logic                  busy_d;

   for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_src
      assign ksrc[k] = i_kernel_src[k*KSRC_BITS +: KSRC_BITS];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_cnt     <= '0;
         o_app_ready <= 1'b0;
      end else if (!o_app_ready) begin
         if (rdy_cnt == RD_LAST) o_app_ready <= 1'b1;
         else                    rdy_cnt     <= rdy_cnt + RD_W'(1);
      end
   end

   // First requesting kernel at or after the pointer, wrapping modulo KERNEL_NUM.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
         cand = IDX_W'((32'(ptr) + i) % KERNEL_NUM);
         if (!grant_valid && i_kernel_irq[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      grant_word                    = '0;
      grant_word[KSRC_BITS-1:0]     = ksrc[grant_idx];
      grant_word[KSRC_BITS +: 8]    = 8'(grant_idx);
   end

   assign grant_take = (state == S_IDLE) && o_app_ready && grant_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Ack has priority over a coincident timeout, so the error flag is only raised without ack.
   always_comb begin
      state_d = state;
      ack_hit = 1'b0;
      to_hit  = 1'b0;
      case (state)
         S_IDLE: if (grant_take) state_d = S_REQ;
         S_REQ: begin
            if (i_interrupt_ack) begin
               ack_hit = 1'b1;
               state_d = S_REL;
            end else if ((ACK_TIMEOUT > 0) && (to_cnt == TO_LAST)) begin
               to_hit  = 1'b1;
               state_d = S_REL;
            end
         end
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      int_d    = o_interrupt;
      src_d    = o_interrupt_src;
      kack_d   = '0;
      err_d    = o_timeout_err;
      ptr_d    = ptr;
      gsel_d   = gsel;
      to_cnt_d = to_cnt;
      busy_d   = (state_d != S_IDLE);
      if (grant_take) begin
         int_d    = 1'b1;
         src_d    = grant_word;
         gsel_d   = grant_idx;
         to_cnt_d = '0;
         ptr_d    = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
      end
      if (state == S_REQ) begin
         if (ack_hit || to_hit) begin
            int_d        = 1'b0;
            kack_d[gsel] = 1'b1;
         end else begin
            to_cnt_d = to_cnt + TO_W'(1);
         end
      end
      if (to_hit)           err_d = 1'b1;
      else if (i_err_clear) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_interrupt      <= 1'b0;
         o_interrupt_src  <= '0;
         o_kernel_irq_ack <= '0;
         o_timeout_err    <= 1'b0;
         o_busy           <= 1'b0;
         ptr              <= '0;
         gsel             <= '0;
         to_cnt           <= '0;
      end else begin
         o_interrupt      <= int_d;
         o_interrupt_src  <= src_d;
         o_kernel_irq_ack <= kack_d;
         o_timeout_err    <= err_d;
         o_busy           <= busy_d;
         ptr              <= ptr_d;
         gsel             <= gsel_d;
         to_cnt           <= to_cnt_d;
      end
   end

endmodule

// File: tb/tb_action_irq_arbiter.sv
// Directed bench for action_irq_arbiter: 8 kernels, READY_DELAY=4, ACK_TIMEOUT=10.
module tb_action_irq_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   irq;
   logic [255:0] ksrc;
   logic [7:0]   kack;
   logic         intr;
   logic [63:0]  isrc;
   logic         iack;
   logic         ready;
   logic         terr;
   logic         eclr;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] src_of [8];

   typedef struct {
      logic [7:0] irq;
      logic       ack;
      logic       e_int;
      logic [7:0] e_idx;
      logic [7:0] e_kack;
      logic       e_busy;
   } vec_t;

   vec_t tbl [11];

   always #5 clk = ~clk;

   action_irq_arbiter #(
      .KERNEL_NUM (8),
      .INT_BITS   (64),
      .KSRC_BITS  (32),
      .READY_DELAY(4),
      .ACK_TIMEOUT(10)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_kernel_irq    (irq),
      .i_kernel_src    (ksrc),
      .o_kernel_irq_ack(kack),
      .o_interrupt     (intr),
      .o_interrupt_src (isrc),
      .i_interrupt_ack (iack),
      .o_app_ready     (ready),
      .o_timeout_err   (terr),
      .i_err_clear     (eclr),
      .o_busy          (busy)
   );

   function automatic logic [63:0] exp_word(input int idx);
      return {24'h0, 8'(idx), src_of[idx]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic e_int, input int e_idx,
                          input logic [7:0] e_kack, input logic e_busy, input logic e_err);
      chk({name, ".int"},  intr, e_int);
      chk({name, ".src"},  isrc, exp_word(e_idx));
      chk({name, ".kack"}, kack, e_kack);
      chk({name, ".busy"}, busy, e_busy);
      chk({name, ".err"},  terr, e_err);
   endtask

   task automatic cycle(input logic [7:0] r, input logic a, input logic c);
      @(negedge clk);
      irq  = r;
      iack = a;
      eclr = c;
      @(posedge clk);
      #1;
   endtask

   // Releases reset with all kernels requesting; leaves the DUT idle with pointer at 1.
   task automatic powerup(input string tag);
      @(negedge clk);
      irq   = 8'hFF;
      iack  = 1'b0;
      eclr  = 1'b0;
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         chk({tag, ".ready"}, ready, (e == 4));
         chk({tag, ".no_int"}, intr, 1'b0);
      end
      @(posedge clk);
      #1;
      chk_out({tag, ".grant0"}, 1'b1, 0, 8'h00, 1'b1, 1'b0);
      cycle(8'hFF, 1'b1, 1'b0);
      chk_out({tag, ".ack0"}, 1'b0, 0, 8'h01, 1'b1, 1'b0);
      cycle(8'h00, 1'b0, 1'b0);
      chk_out({tag, ".rel0"}, 1'b0, 0, 8'h00, 1'b0, 1'b0);
      chk({tag, ".ready_hold"}, ready, 1'b1);
   endtask

   initial begin
      int g;
      for (int k = 0; k < 8; k++) src_of[k] = 32'hC0DE0000 + 32'(k);
      src_of[2] = 32'hAAAA0002;
      src_of[5] = 32'hBBBB0005;
      for (int k = 0; k < 8; k++) ksrc[k*32 +: 32] = src_of[k];

      //          irq    ack   int   idx   kack   busy
      tbl[0]  = '{8'h24, 1'b0, 1'b1, 8'd2, 8'h00, 1'b1};
      tbl[1]  = '{8'h24, 1'b0, 1'b1, 8'd2, 8'h00, 1'b1};
      tbl[2]  = '{8'h24, 1'b0, 1'b1, 8'd2, 8'h00, 1'b1};
      tbl[3]  = '{8'h24, 1'b1, 1'b0, 8'd2, 8'h04, 1'b1};
      tbl[4]  = '{8'h20, 1'b0, 1'b0, 8'd2, 8'h00, 1'b0};
      tbl[5]  = '{8'h20, 1'b0, 1'b1, 8'd5, 8'h00, 1'b1};
      tbl[6]  = '{8'h20, 1'b0, 1'b1, 8'd5, 8'h00, 1'b1};
      tbl[7]  = '{8'h20, 1'b0, 1'b1, 8'd5, 8'h00, 1'b1};
      tbl[8]  = '{8'h20, 1'b1, 1'b0, 8'd5, 8'h20, 1'b1};
      tbl[9]  = '{8'h00, 1'b0, 1'b0, 8'd5, 8'h00, 1'b0};
      tbl[10] = '{8'h00, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0};

      rst_n = 1'b0;
      irq   = 8'h00;
      iack  = 1'b0;
      eclr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.int", intr, 1'b0);
      chk("rst.src", isrc, 64'h0);
      chk("rst.kack", kack, 8'h00);
      chk("rst.ready", ready, 1'b0);
      chk("rst.err", terr, 1'b0);
      chk("rst.busy", busy, 1'b0);

      powerup("pu1");

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].irq, tbl[i].ack, 1'b0);
         chk_out($sformatf("vec%0d", i), tbl[i].e_int, int'(tbl[i].e_idx),
                 tbl[i].e_kack, tbl[i].e_busy, 1'b0);
      end

      // Pointer now at 6; every kernel requesting, acked immediately.
      for (int n = 0; n < 10; n++) begin
         g = (6 + n) % 8;
         cycle(8'hFF, 1'b0, 1'b0);
         chk_out($sformatf("rr%0d.grant", n), 1'b1, g, 8'h00, 1'b1, 1'b0);
         cycle(8'hFF, 1'b1, 1'b0);
         chk_out($sformatf("rr%0d.ack", n), 1'b0, g, 8'(1 << g), 1'b1, 1'b0);
         cycle((n == 9) ? 8'h00 : 8'hFF, 1'b0, 1'b0);
         chk_out($sformatf("rr%0d.rel", n), 1'b0, g, 8'h00, 1'b0, 1'b0);
      end

      // Timeout with err_clear held: set must win on the timeout edge.
      cycle(8'h08, 1'b0, 1'b1);
      chk_out("to.grant", 1'b1, 3, 8'h00, 1'b1, 1'b0);
      for (int j = 1; j <= 9; j++) begin
         cycle(8'h08, 1'b0, 1'b1);
         chk_out($sformatf("to.wait%0d", j), 1'b1, 3, 8'h00, 1'b1, 1'b0);
      end
      cycle(8'h08, 1'b0, 1'b1);
      chk_out("to.expire", 1'b0, 3, 8'h08, 1'b1, 1'b1);
      cycle(8'h00, 1'b0, 1'b0);
      chk_out("to.sticky", 1'b0, 3, 8'h00, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b1);
      chk_out("to.clear", 1'b0, 3, 8'h00, 1'b0, 1'b0);

      // Ack on the tenth cycle coincides with the timeout: no error.
      cycle(8'h08, 1'b0, 1'b0);
      chk_out("tack.grant", 1'b1, 3, 8'h00, 1'b1, 1'b0);
      for (int j = 1; j <= 9; j++) begin
         cycle(8'h08, 1'b0, 1'b0);
         chk_out($sformatf("tack.wait%0d", j), 1'b1, 3, 8'h00, 1'b1, 1'b0);
      end
      cycle(8'h08, 1'b1, 1'b0);
      chk_out("tack.ack", 1'b0, 3, 8'h08, 1'b1, 1'b0);
      cycle(8'h00, 1'b0, 1'b0);
      chk_out("tack.rel", 1'b0, 3, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a request, then pointer restart.
      cycle(8'hFF, 1'b0, 1'b0);
      chk_out("mid.grant", 1'b1, 4, 8'h00, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid.int", intr, 1'b0);
      chk("mid.src", isrc, 64'h0);
      chk("mid.kack", kack, 8'h00);
      chk("mid.ready", ready, 1'b0);
      chk("mid.busy", busy, 1'b0);
      chk("mid.err", terr, 1'b0);

      powerup("pu2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
